// File: rtl/result_mem_pkg.sv
// Shared widths, FSM encoding and output-entry layout for the result memory reader.
package result_mem_pkg;

  localparam int RM_DATA_W = 16;
  localparam int RM_ADDR_W = 8;
  localparam int RM_DEPTH  = 1 << RM_ADDR_W;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t ISSUE = 2'd1;
  localparam state_t DRAIN = 2'd2;

  typedef struct packed {
    logic [RM_DATA_W-1:0] data;
    logic [RM_ADDR_W-1:0] addr;
    logic                 last;
  } entry_t;

endpackage

// File: rtl/result_mem_ram.sv
// Single write port, single registered read port; a read colliding with a write
// to the same address returns the new data.
module result_mem_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] rq
);

  logic [DATA_W-1:0] mem [DEPTH];

  // No reset: contents survive rst_n so stored results can be read after a recovery.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rq <= (we && (wa == ra)) ? wd : mem[ra];
  end

endmodule

// File: rtl/result_mem_reader.sv
// Result memory with a burst read engine: request {start,count}, stream words out
// on a valid/ready interface through a 2-entry credit-protected FIFO.
//
// state | meaning
// IDLE  | waiting for a request, req_ready=1
// ISSUE | issuing reads while credit allows, one address per cycle
// DRAIN | all reads issued, waiting for the last beat to be accepted
module result_mem_reader
  import result_mem_pkg::*;
#(
  parameter int DATA_W = RM_DATA_W,
  parameter int ADDR_W = RM_ADDR_W,
  parameter int DEPTH  = RM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_start,
  input  logic [ADDR_W:0]   req_count,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_last,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W:0] REM_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] REM_ZERO = '0;

  state_t            state;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   remaining;
  logic              err_q;

  logic              inflight;
  logic [ADDR_W-1:0] inflight_addr;
  logic              inflight_last;
  logic [DATA_W-1:0] ram_q;

  entry_t            fifo_mem [2];
  logic              fifo_wp;
  logic              fifo_rp;
  logic [1:0]        fifo_count;

  logic              issue;
  logic              push;
  logic              pop;
  logic [2:0]        occ;

  result_mem_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk (clk),
    .we  (wr_en),
    .wa  (wr_addr),
    .wd  (wr_data),
    .re  (issue),
    .ra  (rptr),
    .rq  (ram_q)
  );

  // Occupancy after this edge excluding a new issue; keeping it below 2 means the
  // read about to be issued always has a FIFO slot when its data lands.
  assign occ       = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = (state == ISSUE) && (occ < 3'd2);
  assign push      = inflight;
  assign rd_valid  = (fifo_count != 2'd0);
  assign pop       = rd_valid && rd_ready;
  assign rd_data   = fifo_mem[fifo_rp].data;
  assign rd_addr   = fifo_mem[fifo_rp].addr;
  assign rd_last   = fifo_mem[fifo_rp].last;
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign err       = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rptr      <= '0;
      remaining <= REM_ZERO;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_count == REM_ZERO) begin
              err_q <= 1'b1;
            end else begin
              rptr      <= req_start;
              remaining <= req_count;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (issue) begin
            rptr      <= rptr + 1'b1;
            remaining <= remaining - REM_ONE;
            if (remaining == REM_ONE) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && rd_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Address and last flag ride alongside the RAM's one-cycle read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight      <= 1'b0;
      inflight_addr <= '0;
      inflight_last <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_addr <= rptr;
        inflight_last <= (remaining == REM_ONE);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
      fifo_wp    <= 1'b0;
      fifo_rp    <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[fifo_wp] <= '{data: ram_q, addr: inflight_addr, last: inflight_last};
        fifo_wp           <= ~fifo_wp;
      end
      if (pop) fifo_rp <= ~fifo_rp;
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_result_mem_reader.sv
// Directed bench for result_mem_reader: table of bursts plus hand-written
// sequences for reset, zero count, blocked request, bypass and mid-burst reset.
module tb_result_mem_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_start;
  logic [8:0]  req_count;
  logic        rd_valid;
  logic        rd_ready;
  logic [15:0] rd_data;
  logic [7:0]  rd_addr;
  logic        rd_last;
  logic        busy;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] model [256];

  always #5 clk = ~clk;

  result_mem_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_start (req_start),
    .req_count (req_count),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_addr   (rd_addr),
    .rd_last   (rd_last),
    .busy      (busy),
    .err       (err)
  );

  typedef struct {
    logic [7:0]  start;
    logic [8:0]  count;
    logic [7:0]  pat;
    bit          full_rate;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
    model[a] = d;
  endtask

  // Cycle 1 is the cycle after the accept edge; beats are checked against the model.
  task automatic run_burst(input logic [7:0] start, input logic [8:0] count,
                           input logic [7:0] pat, input bit full_rate,
                           output logic [15:0] first_d, output logic [15:0] last_d);
    int beat = 0;
    int cyc = 1;
    int first_cyc = -1;
    int last_cyc = -1;
    bit held = 1'b0;
    logic [15:0] hd;
    logic [7:0]  ha;
    logic        hl;
    logic [7:0]  a;
    first_d = '0;
    last_d  = '0;
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_start = start; req_count = count;
    step();
    req_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
    while (beat < int'(count) && cyc < int'(count) * 4 + 40) begin
      rd_ready = pat[7 - ((cyc - 1) % 8)];
      if (held) begin
        chk("stall_data", rd_data, hd);
        chk("stall_addr", rd_addr, ha);
        chk("stall_last", rd_last, hl);
      end
      if (rd_valid && first_cyc < 0) first_cyc = cyc;
      if (rd_valid && rd_ready) begin
        a = start + beat[7:0];
        chk("beat_data", rd_data, model[a]);
        chk("beat_addr", rd_addr, a);
        chk("beat_last", rd_last, (beat == int'(count) - 1));
        if (beat == 0) first_d = rd_data;
        last_d = rd_data;
        beat++;
        last_cyc = cyc;
        held = 1'b0;
      end else if (rd_valid) begin
        held = 1'b1; hd = rd_data; ha = rd_addr; hl = rd_last;
      end else begin
        held = 1'b0;
      end
      step();
      cyc++;
    end
    rd_ready = 1'b0;
    chk("beat_count", beat, count);
    chk("first_valid_cycle", first_cyc, 3);
    if (full_rate) chk("last_accept_cycle", last_cyc, count + 2);
    chk("busy_done", busy, 0);
    step();
    chk("no_extra_beat", rd_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] fd, ld;
    int beats;

    vecs[0] = '{8'd155, 9'd4,  8'hFF,        1'b1, 16'd8,   16'd7};
    vecs[1] = '{8'd155, 9'd4,  8'b01001101,  1'b0, 16'd8,   16'd7};
    vecs[2] = '{8'd254, 9'd4,  8'hFF,        1'b1, 16'd254, 16'd1};
    vecs[3] = '{8'd157, 9'd2,  8'b10101010,  1'b0, 16'd3,   16'd7};
    vecs[4] = '{8'd250, 9'd10, 8'b00110011,  1'b0, 16'd250, 16'd3};

    // Reset with random inputs
    rst_n = 1'b0;
    rd_ready = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    req_valid = 1'b0; req_start = '0; req_count = '0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'($urandom); req_start = 8'($urandom); req_count = 9'($urandom);
      rd_ready = 1'($urandom); wr_en = 1'($urandom);
      wr_addr = 8'($urandom); wr_data = 16'($urandom);
      step();
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_req_ready", req_ready, 1);
    end
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_rd_last", rd_last, 0);
    req_valid = 1'b0; rd_ready = 1'b1; wr_en = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_no_beat", rd_valid, 0);
      chk("idle_busy", busy, 0);
    end
    rd_ready = 1'b0;

    // Full sweep with mem[k]=k
    for (int k = 0; k < 256; k++) wr(8'(k), 16'(k));
    run_burst(8'd0, 9'd256, 8'hFF, 1'b1, fd, ld);
    chk("sweep_first", fd, 16'd0);
    chk("sweep_last", ld, 16'd255);

    wr(8'd155, 16'd8);
    wr(8'd156, 16'd24);
    wr(8'd157, 16'd3);
    wr(8'd158, 16'd7);

    for (int v = 0; v < 5; v++) begin
      run_burst(vecs[v].start, vecs[v].count, vecs[v].pat, vecs[v].full_rate, fd, ld);
      chk($sformatf("vec%0d_first", v), fd, vecs[v].exp_first);
      chk($sformatf("vec%0d_last", v), ld, vecs[v].exp_last);
    end

    // Zero-count request
    req_valid = 1'b1; req_start = 8'd5; req_count = 9'd0;
    step();
    req_valid = 1'b0;
    chk("zero_err_pulse", err, 1);
    chk("zero_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("zero_err_clear", err, 0);
      chk("zero_no_beat", rd_valid, 0);
    end

    // Request during busy is not accepted
    rd_ready = 1'b0;
    req_valid = 1'b1; req_start = 8'd0; req_count = 9'd8;
    step();
    req_start = 8'd20; req_count = 9'd3;
    for (int i = 0; i < 6; i++) begin
      chk("blocked_req_ready", req_ready, 0);
      step();
    end
    req_valid = 1'b0;
    rd_ready = 1'b1;
    beats = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      if (rd_valid) begin
        chk("blocked_addr", rd_addr, 8'(beats));
        beats++;
      end
      step();
    end
    chk("blocked_beats", beats, 8);
    for (int i = 0; i < 3; i++) begin
      chk("blocked_no_second", rd_valid | busy, 0);
      step();
    end
    rd_ready = 1'b0;

    // Write-first bypass: write mem[10] in the cycle its read issues
    req_valid = 1'b1; req_start = 8'd10; req_count = 9'd1;
    step();
    req_valid = 1'b0;
    wr_en = 1'b1; wr_addr = 8'd10; wr_data = 16'hABCD;
    step();
    wr_en = 1'b0;
    model[10] = 16'hABCD;
    rd_ready = 1'b1;
    beats = 0;
    for (int i = 0; i < 10 && beats == 0; i++) begin
      if (rd_valid) begin
        chk("bypass_data", rd_data, 16'hABCD);
        chk("bypass_last", rd_last, 1);
        beats++;
      end
      step();
    end
    chk("bypass_beats", beats, 1);
    chk("bypass_busy", busy, 0);
    rd_ready = 1'b0;

    // Reset in the middle of a 16-word burst
    rd_ready = 1'b1;
    req_valid = 1'b1; req_start = 8'd0; req_count = 9'd16;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("midrst_pre_valid", rd_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_rd_last", rd_last, 0);
    step();
    rst_n = 1'b1;
    rd_ready = 1'b0;
    step();
    run_burst(8'd155, 9'd1, 8'hFF, 1'b1, fd, ld);
    chk("midrst_retained", fd, 16'd8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
